// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the mem port arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE -> OWN -> RELEASE -> IDLE)
//   - REQ_*       : requester slot assignment on the shared mem port
//   - ARB_WORD_WIDTH : default address/data width of the mem port
package mem_port_arbiter_pkg;

  localparam int ARB_WORD_WIDTH = 16;

  // Requester slots: random generator, winnerPolicy, Q-value update engine.
  localparam int REQ_RNG = 0;
  localparam int REQ_WP  = 1;
  localparam int REQ_UPD = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Returns the first asserted request at or after the pointer, wrapping
// cyclically.
//   i_req  : request vector
//   i_ptr  : highest-priority index for this pick
//   o_gnt  : one-hot winner (zero when no request)
//   o_idx  : binary index of the winner (zero when no request)
//   o_any  : at least one request present
module rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin : p_pick
    logic             found;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    cand  = '0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port mem between NUM_REQ masters with
// round-robin arbitration, burst locking and a hold-time limit.
//   clock, nreset            : clock (rising edge), async active-low reset
//   req / lock / wr_en_in    : per-master request, burst lock, write enable
//   addr_in / wdata_in       : per-master address / write data, master i at [i*W +: W]
//   gnt                      : registered one-hot grant
//   rvalid                   : per-master read-data strobe, RD_LAT after a read access
//   busy                     : a grant is held
//   mem_address/mem_wr_en/mem_data_in : mem port, driven from the grantee
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int WORD_WIDTH = ARB_WORD_WIDTH,
  parameter int MAX_HOLD   = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] addr_in,
  input  logic [NUM_REQ-1:0]            wr_en_in,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] wdata_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic                          busy,
  output logic [WORD_WIDTH-1:0]         mem_address,
  output logic                          mem_wr_en,
  output logic [WORD_WIDTH-1:0]         mem_data_in
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t                      r_state;
  logic [NUM_REQ-1:0]              r_gnt;
  logic [IDX_W-1:0]                r_gidx;
  logic [IDX_W-1:0]                r_rr_ptr;
  logic [HOLD_W-1:0]               r_hold_cnt;
  logic [RD_LAT-1:0]               r_rv_vld;
  logic [RD_LAT-1:0][IDX_W-1:0]    r_rv_idx;

  arb_state_t                      w_state_nxt;
  logic [NUM_REQ-1:0]              w_gnt_nxt;
  logic [IDX_W-1:0]                w_gidx_nxt;
  logic [IDX_W-1:0]                w_ptr_nxt;
  logic [HOLD_W-1:0]               w_hold_nxt;

  logic [NUM_REQ-1:0]              w_pick_gnt;
  logic [IDX_W-1:0]                w_pick_idx;
  logic                            w_pick_any;

  logic                            w_g_req;
  logic                            w_g_lock;
  logic                            w_g_wr;
  logic                            w_other_req;
  logic                            w_rd_acc;
  logic [HOLD_W-1:0]               w_hold_inc;
  logic [IDX_W-1:0]                w_ptr_after;
  logic [WORD_WIDTH-1:0]           w_addr;
  logic [WORD_WIDTH-1:0]           w_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // The grant is one-hot, so masking by it selects the grantee's signals.
  assign w_g_req     = |(r_gnt & req);
  assign w_g_lock    = |(r_gnt & lock);
  assign w_g_wr      = |(r_gnt & wr_en_in);
  assign w_other_req = |(req & ~r_gnt);
  assign w_rd_acc    = w_g_req & ~w_g_wr;

  assign w_hold_inc  = (r_hold_cnt == HOLD_W'(MAX_HOLD)) ? r_hold_cnt
                                                        : r_hold_cnt + HOLD_W'(1);
  assign w_ptr_after = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);

  // mem port mux; all zero when nobody holds the grant.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_addr  = addr_in[i*WORD_WIDTH +: WORD_WIDTH];
        w_wdata = wdata_in[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_rr_ptr;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_OWN;
          w_gnt_nxt   = w_pick_gnt;
          w_gidx_nxt  = w_pick_idx;
        end
      end
      ST_OWN: begin
        // Pre-emption fires on the access that brings the count to MAX_HOLD,
        // so an unlocked owner gets exactly MAX_HOLD accesses while others wait.
        if (!w_g_req ||
            ((w_hold_inc == HOLD_W'(MAX_HOLD)) && !w_g_lock && w_other_req)) begin
          w_state_nxt = ST_RELEASE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_after;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt  = w_hold_inc;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gidx     <= w_gidx_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Read-return pipeline carries the requester index, so a read issued in the
  // last OWN cycle still returns to its owner after the grant is gone.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_rv_vld <= '0;
      r_rv_idx <= '0;
    end else begin
      r_rv_vld[0] <= w_rd_acc;
      r_rv_idx[0] <= r_gidx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rv_vld[i] <= r_rv_vld[i-1];
        r_rv_idx[i] <= r_rv_idx[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (r_rv_vld[RD_LAT-1]) begin
      rvalid[r_rv_idx[RD_LAT-1]] = 1'b1;
    end
  end

  assign gnt         = r_gnt;
  assign busy        = (r_state == ST_OWN);
  assign mem_address = w_addr;
  assign mem_data_in = w_wdata;
  assign mem_wr_en   = w_g_req & w_g_wr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NR   = 3;
  localparam int W    = 16;
  localparam int MAXH = 8;

  logic            clock = 1'b0;
  logic            nreset;
  logic [NR-1:0]   req, lock, wr_en_in, gnt, rvalid;
  logic [W-1:0]    a_addr [NR];
  logic [W-1:0]    a_wd   [NR];
  logic [NR*W-1:0] addr_in, wdata_in;
  logic            busy, mem_wr_en;
  logic [W-1:0]    mem_address, mem_data_in;

  assign addr_in  = {a_addr[2], a_addr[1], a_addr[0]};
  assign wdata_in = {a_wd[2], a_wd[1], a_wd[0]};

  mem_port_arbiter #(
    .NUM_REQ    (NR),
    .WORD_WIDTH (W),
    .MAX_HOLD   (MAXH),
    .RD_LAT     (1)
  ) dut (
    .clock       (clock),
    .nreset      (nreset),
    .req         (req),
    .lock        (lock),
    .addr_in     (addr_in),
    .wr_en_in    (wr_en_in),
    .wdata_in    (wdata_in),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .busy        (busy),
    .mem_address (mem_address),
    .mem_wr_en   (mem_wr_en),
    .mem_data_in (mem_data_in)
  );

  always #5 clock = ~clock;

  // Single-port sync-read memory, read-first; preloaded with A000 + address.
  logic [W-1:0] mem [256];
  logic [W-1:0] mem_rdata;
  always @(posedge clock) begin
    mem_rdata <= mem[mem_address[7:0]];
    if (mem_wr_en) mem[mem_address[7:0]] = mem_data_in;
  end

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } rd_exp_t;

  rd_exp_t exp_q [$];
  rd_exp_t mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [W-1:0] data);
    rd_exp_t ne;
    ne.idx  = 2'(idx);
    ne.data = data;
    exp_q.push_back(ne);
  endtask

  task automatic push_rd(input int idx, input logic [W-1:0] a);
    push_exp(idx, 16'hA000 + {8'h00, a[7:0]});
  endtask

  task automatic drain(input string tag);
    repeat (3) step();
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Read-return scoreboard and grant sanity, sampled mid-cycle.
  always @(negedge clock) begin
    if (nreset) begin
      check_eq("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (rvalid != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("rv_unexpected", 32'(rvalid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("rv_idx", 32'(rvalid), 32'(1 << mon_e.idx));
          check_eq("rv_data", 32'(mem_rdata), 32'(mon_e.data));
        end
      end
    end
  end

  function automatic logic [2:0] exp_pre(input int t);
    if (t >= 1  && t <= 8)  return 3'b001;
    if (t >= 11 && t <= 13) return 3'b100;
    if (t >= 16 && t <= 20) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exp_lock(input int t);
    if (t >= 1  && t <= 20) return 3'b001;
    if (t >= 23 && t <= 25) return 3'b100;
    return 3'b000;
  endfunction

  // Master 0 requests for 20 cycles, master 2 joins at cycle 3.
  task automatic run_sched(input bit use_lock);
    int         len;
    logic [2:0] eg;
    len = use_lock ? 28 : 23;
    for (int t = 0; t < len; t++) begin
      req[REQ_RNG] = (t <= 19);
      req[REQ_UPD] = use_lock ? (t >= 3 && t <= 24) : (t >= 3 && t <= 12);
      lock[REQ_RNG] = use_lock;
      a_addr[0] = 16'h0030 + 16'(t);
      a_addr[2] = 16'h0050 + 16'(t);
      eg = use_lock ? exp_lock(t) : exp_pre(t);
      check_eq(use_lock ? "lock_gnt" : "pre_gnt", 32'(gnt), 32'(eg));
      for (int g = 0; g < NR; g++)
        if (eg[g] && req[g]) push_rd(g, a_addr[g]);
      step();
    end
    req  = '0;
    lock = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    nreset   = 1'b1;
    req      = '1;
    lock     = '0;
    wr_en_in = '1;
    for (int g = 0; g < NR; g++) begin
      a_addr[g] = 16'h005A + 16'(g);
      a_wd[g]   = 16'h1111 * 16'(g + 1);
    end
    #2 nreset = 1'b0;

    // Reset state with all masters requesting writes.
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_gnt",    32'(gnt), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_wr_en",  32'(mem_wr_en), 32'd0);
    check_eq("rst_addr",   32'(mem_address), 32'd0);
    check_eq("rst_wdata",  32'(mem_data_in), 32'd0);
    req      = '0;
    wr_en_in = '0;
    nreset   = 1'b1;
    step();
    check_eq("idle_gnt", 32'(gnt), 32'd0);

    // Simultaneous requests: order 0,1,2 with two dead cycles between owners.
    req = 3'b111;
    for (int g = 0; g < NR; g++) a_addr[g] = 16'h0020 + 16'(g * 4);
    step();
    for (int o = 0; o < NR; o++) begin
      for (int k = 0; k < 2; k++) begin
        check_eq("sim_gnt", 32'(gnt), 32'(1 << o));
        a_addr[o] = 16'h0020 + 16'(o * 4 + k);
        push_rd(o, a_addr[o]);
        step();
      end
      req[o] = 1'b0;
      check_eq("sim_gnt_tail", 32'(gnt), 32'(1 << o));
      step();
      check_eq("sim_gap_release", 32'(gnt), 32'd0);
      step();
      check_eq("sim_gap_idle", 32'(gnt), 32'd0);
      step();
    end
    // Pointer wrapped back to 0: master 0 beats master 2.
    req = 3'b101;
    step();
    check_eq("sim_ptr_wrap", 32'(gnt), 32'b001);
    req = '0;
    drain("sim_drain");

    // Single master reading 0x10..0x13.
    req[REQ_WP] = 1'b1;
    a_addr[1] = 16'h0010;
    step();
    check_eq("single_gnt",  32'(gnt), 32'b010);
    check_eq("single_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      a_addr[1] = 16'h0010 + 16'(k);
      #1;
      if (k == 0) check_eq("single_addr", 32'(mem_address), 32'h0010);
      push_rd(1, a_addr[1]);
      step();
    end
    req = '0;
    drain("single_drain");

    // Reset during a master-1 burst.
    req[REQ_WP] = 1'b1;
    a_addr[1] = 16'h0018;
    step();
    check_eq("rstmid_gnt", 32'(gnt), 32'b010);
    push_rd(1, a_addr[1]);
    step();
    a_addr[1]   = 16'h0090;
    a_wd[1]     = 16'h1234;
    wr_en_in[1] = 1'b1;
    #5;
    nreset = 1'b0;
    #1;
    check_eq("rstmid_gnt0",   32'(gnt), 32'd0);
    check_eq("rstmid_rvalid", 32'(rvalid), 32'd0);
    check_eq("rstmid_busy",   32'(busy), 32'd0);
    check_eq("rstmid_wr_en",  32'(mem_wr_en), 32'd0);
    check_eq("rstmid_addr",   32'(mem_address), 32'd0);
    check_eq("rstmid_wdata",  32'(mem_data_in), 32'd0);
    req      = '0;
    wr_en_in = '0;
    step();
    step();
    nreset = 1'b1;
    req    = 3'b110;
    step();
    check_eq("rstmid_first_gnt", 32'(gnt), 32'b010);
    req = '0;
    drain("rstmid_drain");

    // Pre-emption after MAX_HOLD accesses, then lock suppressing it.
    run_sched(1'b0);
    drain("pre_drain");
    run_sched(1'b1);
    drain("lock_drain");

    // Write gating: master 2 write held off until it owns the port.
    req[REQ_WP] = 1'b1;
    a_addr[1] = 16'h0011;
    step();
    check_eq("wg_gnt1", 32'(gnt), 32'b010);
    req[REQ_UPD] = 1'b1;
    wr_en_in[2]  = 1'b1;
    a_addr[2]    = 16'h0040;
    a_wd[2]      = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("wg_blocked", 32'(mem_wr_en), 32'd0);
      push_rd(1, a_addr[1]);
      step();
    end
    req[REQ_WP] = 1'b0;
    #1;
    check_eq("wg_blocked_tail", 32'(mem_wr_en), 32'd0);
    step();
    check_eq("wg_release", 32'(gnt), 32'd0);
    step();
    check_eq("wg_idle", 32'(gnt), 32'd0);
    step();
    check_eq("wg_gnt2", 32'(gnt), 32'b100);
    #1;
    check_eq("wg_wr_en",  32'(mem_wr_en), 32'd1);
    check_eq("wg_addr",   32'(mem_address), 32'h0040);
    check_eq("wg_wdata",  32'(mem_data_in), 32'hBEEF);
    step();
    wr_en_in[2] = 1'b0;
    push_exp(2, 16'hBEEF);
    step();
    req = '0;
    drain("wg_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
